// File: rtl/xtea_decrypt_core.sv
// Iterative XTEA block decipher: one half-round per clock, valid/ready on both sides.
// Optional abort input enabled by defining XTEA_DEC_ABORT_EN.
module xtea_decrypt_core #(
  parameter int unsigned ROUNDS = 32,
  parameter logic [31:0] DELTA  = 32'h9E3779B9
) (
  input  logic         clk,
  input  logic         reset,
`ifdef XTEA_DEC_ABORT_EN
  input  logic         abort,
`endif
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [63:0]  data_in,
  input  logic [127:0] key_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [63:0]  data_out,
  output logic         busy
);

  localparam logic [31:0] SumInit   = DELTA * ROUNDS;
  localparam logic [6:0]  RoundsCnt = 7'(ROUNDS);

  typedef enum logic [1:0] {StIdle, StRunZ, StRunY, StDone} state_e;

  state_e         state_q, state_d;
  logic [31:0]    v0_q, v0_d, v1_q, v1_d, sum_q, sum_d;
  logic [127:0]   key_q, key_d;
  logic [6:0]     cnt_q, cnt_d;
  logic [63:0]    data_out_q, data_out_d;

  logic [31:0]    k_z, k_y, f_z, f_y, v0_new;
  logic [6:0]     cnt_inc;
  logic           abort_req;

`ifdef XTEA_DEC_ABORT_EN
  assign abort_req = abort;
`else
  assign abort_req = 1'b0;
`endif

  // z-half keys off sum[12:11], y-half off sum[1:0]
  assign k_z     = key_q[{sum_q[12:11], 5'd0} +: 32];
  assign k_y     = key_q[{sum_q[1:0], 5'd0} +: 32];
  assign f_z     = (((v0_q << 4) ^ (v0_q >> 5)) + v0_q) ^ (sum_q + k_z);
  assign f_y     = (((v1_q << 4) ^ (v1_q >> 5)) + v1_q) ^ (sum_q + k_y);
  assign v0_new  = v0_q - f_y;
  assign cnt_inc = cnt_q + 7'd1;

  always_comb begin
    state_d    = state_q;
    v0_d       = v0_q;
    v1_d       = v1_q;
    sum_d      = sum_q;
    key_d      = key_q;
    cnt_d      = cnt_q;
    data_out_d = data_out_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          v0_d    = data_in[63:32];
          v1_d    = data_in[31:0];
          key_d   = key_in;
          sum_d   = SumInit;
          cnt_d   = '0;
          state_d = StRunZ;
        end
      end
      StRunZ: begin
        v1_d    = v1_q - f_z;
        sum_d   = sum_q - DELTA;
        state_d = StRunY;
      end
      StRunY: begin
        v0_d  = v0_new;
        cnt_d = cnt_inc;
        if (cnt_inc == RoundsCnt) begin
          data_out_d = {v0_new, v1_q};
          state_d    = StDone;
        end else begin
          state_d = StRunZ;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
    // Abort drops the in-flight block; data_out keeps the previous result.
    if (abort_req && (state_q == StRunZ || state_q == StRunY)) begin
      state_d = StIdle;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      v0_q       <= '0;
      v1_q       <= '0;
      sum_q      <= '0;
      key_q      <= '0;
      cnt_q      <= '0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      v0_q       <= v0_d;
      v1_q       <= v1_d;
      sum_q      <= sum_d;
      key_q      <= key_d;
      cnt_q      <= cnt_d;
      data_out_q <= data_out_d;
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign busy      = (state_q == StRunZ) || (state_q == StRunY);
  assign data_out  = data_out_q;

endmodule

// File: doc/xtea_decrypt_core.md
Name: xtea_decrypt_core

Overview:
- Iterative XTEA block decipher. Takes one 64-bit ciphertext block and a 128-bit key, computes one half-round per clock, and returns the 64-bit plaintext.
- It is the inverse of the encrypt datapath. It uses the same key-segment selection rule: z-half uses key word ((sum >> 11) & 3); y-half uses key word (sum & 3).
- It sits between the decrypt-side input buffer and the output stream. Valid/ready handshake on both sides.

Parameters:
- ROUNDS, 32, number of full XTEA cycles; legal range 1..64.
- DELTA, 32'h9E3779B9, key-schedule constant.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  ciphertext block and key present.
- in_ready  output  1  core can accept a block (high only in IDLE).
- data_in  input  64  ciphertext; [63:32]=v0, [31:0]=v1.
- key_in  input  128  key; word k[i] = key_in[32*i+31 : 32*i], i=0..3.
- out_valid  output  1  plaintext valid.
- out_ready  input  1  downstream accepts plaintext.
- data_out  output  64  plaintext; same packing as data_in.
- busy  output  1  high in RUN_Z or RUN_Y.

Behaviour:
- Reset state (clk edge with reset=1):
  - state=IDLE; in_ready=1, out_valid=0, busy=0, data_out=0.
  - Internal v0, v1, sum, key and counter are cleared to 0.
  - Reset has priority over every other event, including mid-operation; any in-flight block is discarded with no output.
- States:
  - IDLE: accept when in_valid && in_ready.
    - On the accept edge: latch v0, v1 and the key.
    - sum <= (DELTA*ROUNDS) mod 2^32. For ROUNDS=32 this is 32'hC6EF3720.
    - Clear the round counter; go to RUN_Z.
  - RUN_Z (one edge):
    - v1 <= v1 - ((((v0<<4) ^ (v0>>5)) + v0) ^ (sum + k[(sum>>11)&3])).
    - sum <= sum - DELTA.
    - Go to RUN_Y.
  - RUN_Y (one edge):
    - v0 <= v0 - ((((v1<<4) ^ (v1>>5)) + v1) ^ (sum + k[sum&3])).
    - RUN_Y uses the sum value already decremented in RUN_Z.
    - Increment the counter. If the counter reaches ROUNDS, go to DONE and load data_out <= {new v0, v1}; otherwise go to RUN_Z.
  - DONE: out_valid=1. On an edge with out_ready=1, go to IDLE and clear out_valid. data_out holds its value after leaving DONE.
- Arithmetic:
  - All add, subtract and shift operations are 32-bit modulo 2^32.
  - Shifts are logical.
  - sum wraps naturally. After the final round sum equals 0 for any ROUNDS, because DELTA*ROUNDS is subtracted exactly.
- Latency:
  - Accept edge, then 2*ROUNDS edges, then out_valid is high. That is 64 edges for ROUNDS=32.
  - Throughput is one block per 2*ROUNDS+2 cycles minimum (accept edge + 2*ROUNDS half-rounds + DONE handshake edge).
- Handshake rules:
  - in_ready is combinationally (state==IDLE). A new block can never be accepted while out_valid is high; no overlap.
  - data_in, key_in and in_valid are ignored outside IDLE. The latched key is used for the whole block, even if key_in changes.
  - While out_valid=1 and out_ready=0, data_out and out_valid are held stable indefinitely.
  - out_ready while not in DONE has no effect.

Optional Feature:
- Macro XTEA_DEC_ABORT_EN.
- Defined:
  - Adds port abort (input, 1).
  - In RUN_Z or RUN_Y, abort=1 on an edge returns to IDLE, clears busy and the counter, and produces no out_valid. data_out is unchanged.
  - In IDLE and DONE, abort is ignored.
  - If reset and abort coincide, reset wins (same end state).
- Undefined: the port does not exist; every block runs to completion unless reset.

Test Plan:
- Standard vector:
  - Stimulus: key_in=128'h0C0D0E0F_08090A0B_04050607_00010203, data_in=64'h497DF3D0_72612CB5.
  - Response: data_out=64'h41424344_45464748; out_valid first high 64 edges after accept.
- Zero vector:
  - Stimulus: key_in=0, data_in=64'hDEE9D4D8_F7131ED9.
  - Response: data_out=64'h0.
- Backpressure:
  - Stimulus: hold out_ready=0 for 10 cycles after out_valid, and pulse in_valid with new data meanwhile.
  - Response: data_out stable, in_ready=0, new block not accepted; after out_ready=1, in_ready returns 1 the next cycle.
- Key change mid-block:
  - Stimulus: alter key_in and data_in every cycle during RUN.
  - Response: result identical to the standard vector.
- Reset mid-operation:
  - Stimulus: assert reset at half-round 20.
  - Response: next cycle in_ready=1, busy=0, out_valid=0, data_out=0; a following standard-vector block decrypts correctly.
- Abort (XTEA_DEC_ABORT_EN defined):
  - Stimulus: abort at half-round 5.
  - Response: IDLE next cycle, no out_valid pulse, data_out unchanged.
